write_cmd_route_arb: RTL and testbench

Parametrised, registered successor to the per-direction write-command selector. Each of CH_NUM channels carries two write sources: a direction write command (cmd) and a linefill write (fill). Each source targets one of RAM_PER_CH RAM write ports in its channel. The block routes each source to its port, arbitrates same-port conflicts with fill priority plus anti-starvation, and drives every RAM port from a one-entry valid/ready output register. It sits between the channel-map write path and the RAM write ports.

---
 rtl/write_cmd_route_arb_if.sv | 38 +++
 rtl/write_cmd_route_arb.sv | 91 +++++++++
 tb/tb_write_cmd_route_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/write_cmd_route_arb_if.sv
// Write-command bundle between the per-channel sources (cmd, fill) and the RAM write ports.
// The router uses the slave view. A source/sink model such as a bench uses the master view.
interface write_cmd_route_arb_if #(
  parameter int CH_NUM     = 4,
  parameter int RAM_PER_CH = 2,
  parameter int PLD_W      = 128,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = $clog2(RAM_PER_CH);
  localparam int NP    = CH_NUM * RAM_PER_CH;

  // Handshakes are strict valid/ready.
  // A transfer happens on a rising clk edge where vld and rdy are both 1.
  // A source that raises vld keeps vld, sel and pld steady until rdy is seen.
  // rdy may depend combinationally on vld.
  logic [CH_NUM-1:0]       cmd_vld;
  logic [CH_NUM-1:0]       cmd_rdy;
  logic [CH_NUM*SEL_W-1:0] cmd_sel;
  logic [CH_NUM*PLD_W-1:0] cmd_pld;
  logic [CH_NUM-1:0]       fill_vld;
  logic [CH_NUM-1:0]       fill_rdy;
  logic [CH_NUM*SEL_W-1:0] fill_sel;
  logic [CH_NUM*PLD_W-1:0] fill_pld;
  logic [NP-1:0]           ram_vld;
  logic [NP-1:0]           ram_rdy;
  logic [NP*PLD_W-1:0]     ram_pld;
  logic [CNT_W-1:0]        conflict_cnt;

  modport slave (
    input  cmd_vld, cmd_sel, cmd_pld, fill_vld, fill_sel, fill_pld, ram_rdy,
    output cmd_rdy, fill_rdy, ram_vld, ram_pld, conflict_cnt
  );

  modport master (
    output cmd_vld, cmd_sel, cmd_pld, fill_vld, fill_sel, fill_pld, ram_rdy,
    input  cmd_rdy, fill_rdy, ram_vld, ram_pld, conflict_cnt
  );
endinterface

// File: rtl/write_cmd_route_arb.sv
// Routes per-channel cmd/fill writes to RAM write ports through one-entry output registers.
// A same-port conflict goes to fill, except that cmd is forced through after STARVE_MAX straight fill wins.
module write_cmd_route_arb #(
  parameter int CH_NUM     = 4,
  parameter int RAM_PER_CH = 2,
  parameter int PLD_W      = 128,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  write_cmd_route_arb_if.slave bus
);
  localparam int SEL_W = $clog2(RAM_PER_CH);
  localparam int NP    = CH_NUM * RAM_PER_CH;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam int SUM_W = CNT_W + $clog2(CH_NUM + 1);

  logic [NP-1:0]                 ram_vld_q, ram_vld_d;
  logic [NP-1:0][PLD_W-1:0]      ram_pld_q, ram_pld_d;
  logic [CH_NUM-1:0][ST_W-1:0]   starve_q, starve_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [NP-1:0]                 acc;
  logic [CH_NUM-1:0][SEL_W-1:0]  cs, fs;
  logic [CH_NUM-1:0]             conflict, cmd_win, fill_win, cmd_rdy, fill_rdy;
  logic [SUM_W-1:0]              sum;

  assign cs  = bus.cmd_sel;
  assign fs  = bus.fill_sel;
  // A port takes a new entry when it is empty, or when it drains in this same cycle.
  assign acc = ~ram_vld_q | bus.ram_rdy;

  always_comb begin
    conflict  = '0;
    cmd_win   = '0;
    fill_win  = '0;
    cmd_rdy   = '0;
    fill_rdy  = '0;
    starve_d  = starve_q;
    ram_vld_d = ram_vld_q & ~bus.ram_rdy;
    ram_pld_d = ram_pld_q;
    sum       = SUM_W'(cnt_q);
    for (int c = 0; c < CH_NUM; c++) begin
      conflict[c] = bus.cmd_vld[c] & bus.fill_vld[c] & (cs[c] == fs[c]);
      cmd_win[c]  = !conflict[c] || (starve_q[c] == ST_W'(STARVE_MAX));
      fill_win[c] = !conflict[c] || (starve_q[c] <  ST_W'(STARVE_MAX));
      cmd_rdy[c]  = bus.cmd_vld[c]  & cmd_win[c]  & acc[c*RAM_PER_CH + int'(cs[c])];
      fill_rdy[c] = bus.fill_vld[c] & fill_win[c] & acc[c*RAM_PER_CH + int'(fs[c])];

      // An accepted cmd always clears starvation. Only a conflict fill win counts toward it.
      if (cmd_rdy[c])
        starve_d[c] = '0;
      else if (conflict[c] && fill_rdy[c])
        starve_d[c] = starve_q[c] + ST_W'(1);

      if (conflict[c] && acc[c*RAM_PER_CH + int'(fs[c])])
        sum = sum + SUM_W'(1);

      if (fill_rdy[c]) begin
        ram_vld_d[c*RAM_PER_CH + int'(fs[c])] = 1'b1;
        ram_pld_d[c*RAM_PER_CH + int'(fs[c])] = bus.fill_pld[c*PLD_W +: PLD_W];
      end
      if (cmd_rdy[c]) begin
        ram_vld_d[c*RAM_PER_CH + int'(cs[c])] = 1'b1;
        ram_pld_d[c*RAM_PER_CH + int'(cs[c])] = bus.cmd_pld[c*PLD_W +: PLD_W];
      end
    end
    cnt_d = (sum[SUM_W-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_vld_q <= '0;
      ram_pld_q <= '0;
      starve_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ram_vld_q <= ram_vld_d;
      ram_pld_q <= ram_pld_d;
      starve_q  <= starve_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.cmd_rdy      = cmd_rdy;
  assign bus.fill_rdy     = fill_rdy;
  assign bus.ram_vld      = ram_vld_q;
  assign bus.ram_pld      = ram_pld_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_write_cmd_route_arb.sv
// Directed bench for write_cmd_route_arb: routing, arbitration/starvation, backpressure,
// counter saturation (second instance with a 2-bit counter) and asynchronous reset.
module tb_write_cmd_route_arb;
  localparam int CH = 4, RPC = 2, PW = 16, NP = CH * RPC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  write_cmd_route_arb_if #(.CH_NUM(CH), .RAM_PER_CH(RPC), .PLD_W(PW), .CNT_W(16)) if0 ();
  write_cmd_route_arb_if #(.CH_NUM(CH), .RAM_PER_CH(RPC), .PLD_W(PW), .CNT_W(2))  if1 ();

  write_cmd_route_arb #(.CH_NUM(CH), .RAM_PER_CH(RPC), .PLD_W(PW), .STARVE_MAX(3), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  write_cmd_route_arb #(.CH_NUM(CH), .RAM_PER_CH(RPC), .PLD_W(PW), .STARVE_MAX(3), .CNT_W(2))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if1.cmd_vld  = if0.cmd_vld;
  assign if1.cmd_sel  = if0.cmd_sel;
  assign if1.cmd_pld  = if0.cmd_pld;
  assign if1.fill_vld = if0.fill_vld;
  assign if1.fill_sel = if0.fill_sel;
  assign if1.fill_pld = if0.fill_pld;
  assign if1.ram_rdy  = if0.ram_rdy;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int c, input logic v, input logic sel, input logic [PW-1:0] pld);
    if0.cmd_vld[c] = v;
    if0.cmd_sel[c] = sel;
    if0.cmd_pld[c*PW +: PW] = pld;
  endtask

  task automatic set_fill(input int c, input logic v, input logic sel, input logic [PW-1:0] pld);
    if0.fill_vld[c] = v;
    if0.fill_sel[c] = sel;
    if0.fill_pld[c*PW +: PW] = pld;
  endtask

  task automatic push(input int p, input logic [PW-1:0] pld);
    exp_q.push_back({p[2:0], pld});
  endtask

  function automatic logic [31:0] sat2(input int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  // Each RAM write completes when vld && rdy at the clock edge; check it against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (if0.ram_vld[p] && if0.ram_rdy[p]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ram_write_unexpected: port %0d pld 0x%0h, expected none", p,
                     if0.ram_pld[p*PW +: PW]);
          end else begin
            chk("ram_write", {13'd0, p[2:0], if0.ram_pld[p*PW +: PW]}, {13'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // Both sources of ch0 target port 0. Fill wins three times, then cmd is forced through, and the pattern repeats.
  task automatic run_starve(input int n, input logic [PW-1:0] fbase, input logic [PW-1:0] cbase);
    logic [PW-1:0] fp, cp;
    logic cw;
    fp = fbase;
    cp = cbase;
    set_fill(0, 1'b1, 1'b0, fp);
    set_cmd(0, 1'b1, 1'b0, cp);
    for (int i = 0; i < n; i++) begin
      cw = ((i % 4) == 3);
      @(negedge clk);
      chk("conflict_cnt", 32'(if0.conflict_cnt), 32'(exp_cnt));
      chk("conflict_cnt_sat", 32'(if1.conflict_cnt), sat2(exp_cnt));
      chk("starve_cmd_rdy", 32'(if0.cmd_rdy[0]), 32'(cw));
      chk("starve_fill_rdy", 32'(if0.fill_rdy[0]), 32'(!cw));
      if (cw) begin
        push(0, cp);
        cp++;
      end else begin
        push(0, fp);
        fp++;
      end
      exp_cnt++;
      cyc();
      set_fill(0, 1'b1, 1'b0, fp);
      set_cmd(0, 1'b1, 1'b0, cp);
    end
    set_fill(0, 1'b0, 1'b0, '0);
    set_cmd(0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if0.cmd_vld = '0;  if0.cmd_sel = '0;  if0.cmd_pld = '0;
    if0.fill_vld = '0; if0.fill_sel = '0; if0.fill_pld = '0;
    if0.ram_rdy = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_vld", 32'(if0.ram_vld), 32'd0);
    chk("rst_ram_pld_nonzero", 32'(|if0.ram_pld), 32'd0);
    chk("rst_conflict_cnt", 32'(if0.conflict_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Route: ch1 cmd to port 1 of channel 1, which is global port 3.
    set_cmd(1, 1'b1, 1'b1, 16'h00A5);
    @(negedge clk);
    chk("route_cmd_rdy", 32'(if0.cmd_rdy), 32'b0010);
    chk("route_fill_rdy", 32'(if0.fill_rdy), 32'b0000);
    push(3, 16'h00A5);
    cyc();
    set_cmd(1, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("route_ram_vld", 32'(if0.ram_vld), 32'h08);
    chk("route_ram_pld", 32'(if0.ram_pld[3*PW +: PW]), 32'h00A5);
    cyc();

    // No conflict: ch2 fill goes to port 4 and ch2 cmd goes to port 5.
    set_fill(2, 1'b1, 1'b0, 16'h0011);
    set_cmd(2, 1'b1, 1'b1, 16'h0022);
    @(negedge clk);
    chk("noconf_cmd_rdy", 32'(if0.cmd_rdy), 32'b0100);
    chk("noconf_fill_rdy", 32'(if0.fill_rdy), 32'b0100);
    push(4, 16'h0011);
    push(5, 16'h0022);
    cyc();
    set_fill(2, 1'b0, 1'b0, '0);
    set_cmd(2, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("noconf_ram_vld", 32'(if0.ram_vld), 32'h30);
    chk("noconf_ram_pld4", 32'(if0.ram_pld[4*PW +: PW]), 32'h0011);
    chk("noconf_cnt", 32'(if0.conflict_cnt), 32'd0);
    cyc();

    // Starvation: winners per cycle are F,F,F,C,F,F,F,C.
    run_starve(8, 16'h0100, 16'h0200);
    @(negedge clk);
    chk("starve_cnt_final", 32'(if0.conflict_cnt), 32'd8);
    chk("sat_cnt_final", 32'(if1.conflict_cnt), 32'd3);
    cyc();

    // Backpressure on port 0.
    set_cmd(0, 1'b1, 1'b0, 16'h0300);
    @(negedge clk);
    chk("bp_first_rdy", 32'(if0.cmd_rdy[0]), 32'd1);
    push(0, 16'h0300);
    cyc();
    if0.ram_rdy[0] = 1'b0;
    set_cmd(0, 1'b1, 1'b0, 16'h0301);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_rdy", 32'(if0.cmd_rdy[0]), 32'd0);
      chk("bp_hold_vld", 32'(if0.ram_vld[0]), 32'd1);
      chk("bp_hold_pld", 32'(if0.ram_pld[0 +: PW]), 32'h0300);
      cyc();
    end
    if0.ram_rdy[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      set_cmd(0, 1'b1, 1'b0, 16'(16'h0300 + k));
      @(negedge clk);
      chk("bp_stream_rdy", 32'(if0.cmd_rdy[0]), 32'd1);
      push(0, 16'(16'h0300 + k));
      cyc();
    end
    set_cmd(0, 1'b0, 1'b0, '0);
    @(negedge clk);
    cyc();

    // Reset mid-traffic: load ports 0..3 with ch0 starvation count at 2, then reset.
    set_fill(0, 1'b1, 1'b0, 16'h0400);
    set_cmd(0, 1'b1, 1'b0, 16'h04FF);
    @(negedge clk);
    chk("rst_pre_fill_rdy0", 32'(if0.fill_rdy[0]), 32'd1);
    chk("rst_pre_cmd_rdy0", 32'(if0.cmd_rdy[0]), 32'd0);
    push(0, 16'h0400);
    exp_cnt++;
    cyc();
    set_fill(0, 1'b1, 1'b0, 16'h0401);
    @(negedge clk);
    chk("rst_pre_fill_rdy1", 32'(if0.fill_rdy[0]), 32'd1);
    push(0, 16'h0401);
    exp_cnt++;
    cyc();
    if0.ram_rdy = '0;
    set_fill(0, 1'b1, 1'b1, 16'h0402);
    set_cmd(1, 1'b1, 1'b0, 16'h0410);
    set_fill(1, 1'b1, 1'b1, 16'h0411);
    @(negedge clk);
    chk("rst_pre_fill_rdy", 32'(if0.fill_rdy), 32'b0011);
    chk("rst_pre_cmd_rdy", 32'(if0.cmd_rdy), 32'b0010);
    push(1, 16'h0402);
    push(2, 16'h0410);
    push(3, 16'h0411);
    cyc();
    if0.cmd_vld = '0;
    if0.fill_vld = '0;
    @(negedge clk);
    chk("rst_pre_ram_vld", 32'(if0.ram_vld[3:0]), 32'hF);
    chk("rst_pre_cnt", 32'(if0.conflict_cnt), 32'(exp_cnt));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ram_vld", 32'(if0.ram_vld), 32'd0);
    chk("rst_async_cnt", 32'(if0.conflict_cnt), 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    if0.ram_rdy = '1;
    // A cleared starvation count gives three fill wins before cmd is forced through.
    run_starve(4, 16'h0500, 16'h05F0);
    @(negedge clk);
    chk("post_rst_cnt", 32'(if0.conflict_cnt), 32'd4);
    cyc();
    repeat (3) cyc();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
